fifo_burst_reader: RTL and testbench

- Consumer side of the team's single-clock FIFO: drains words through the FIFO pop interface (rd_en / f_empty, registered data_out one cycle after pop).
- Re-presents the words as a valid/ready stream.
- Bursts of exactly burst_len words are started by a start pulse; done pulses on completion.
- 2-entry skid buffer sustains one word/cycle despite the FIFO's read latency and downstream backpressure.

---
 rtl/fifo_burst_reader_pkg.sv | 14 +
 rtl/fifo_burst_reader_rd_skid_buf.sv | 46 ++++
 rtl/fifo_burst_reader.sv | 125 ++++++++++++
 tb/tb_fifo_burst_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared FSM encoding and skid buffer sizing for fifo_burst_reader.
package fifo_burst_reader_pkg;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_burst_reader_rd_skid_buf.sv
// rd_skid_buf: 2-entry FIFO-ordered skid buffer between the FIFO read port and the stream.
// The writer guarantees space (credit rule in the parent); no full check here.
module rd_skid_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [SKID_CNT_W-1:0] cnt_q;
  logic                  xfer_c;

  assign xfer_c   = rd_valid & rd_ready;
  assign rd_valid = (cnt_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  // Entry storage, pointers and occupancy; simultaneous write and read keeps count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (xfer_c) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + SKID_CNT_W'(wr_en) - SKID_CNT_W'(xfer_c);
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops burst_len words from the single-clock FIFO and re-presents
// them as a valid/ready stream. Optional macro FIFO_RD_PARITY_EN adds out_par
// (XOR reduction of out_data, stored alongside each skid entry).
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned LENWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LENWIDTH-1:0]  burst_len,
  input  logic                 f_empty,
  input  logic [DATAWIDTH-1:0] fifo_data,
  output logic                 rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 busy,
  output logic                 done
`ifdef FIFO_RD_PARITY_EN
  ,
  output logic                 out_par
`endif
);

`ifdef FIFO_RD_PARITY_EN
  localparam int unsigned ENTRY_W = DATAWIDTH + 1;
`else
  localparam int unsigned ENTRY_W = DATAWIDTH;
`endif
  localparam int unsigned OCC_W = SKID_CNT_W + 1;

  state_t                state_q, state_d;
  logic [LENWIDTH-1:0]   len_q;
  logic [LENWIDTH-1:0]   issued_q;
  logic [LENWIDTH-1:0]   accepted_q;
  logic                  inflight_q;
  logic [SKID_CNT_W-1:0] skid_cnt;
  logic [ENTRY_W-1:0]    skid_wr_data;
  logic [ENTRY_W-1:0]    skid_rd_data;
  logic [OCC_W-1:0]      occ_c;
  logic                  xfer_c;
  logic                  start_ok_c;

  assign xfer_c     = out_valid & out_ready;
  assign start_ok_c = (state_q == ST_IDLE) && start && (burst_len != '0);

  // Words owed to the skid buffer once this cycle's transfer leaves; a new pop needs a free slot.
  assign occ_c = OCC_W'(skid_cnt) + OCC_W'(inflight_q) - OCC_W'(xfer_c);

  assign rd_en = (state_q == ST_RUN) && !f_empty && (issued_q < len_q)
                 && (occ_c < OCC_W'(SKID_DEPTH));

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

`ifdef FIFO_RD_PARITY_EN
  assign skid_wr_data = {^fifo_data, fifo_data};
  assign out_par      = skid_rd_data[DATAWIDTH];
`else
  assign skid_wr_data = fifo_data;
`endif
  assign out_data = skid_rd_data[DATAWIDTH-1:0];

  // FIFO data_out is valid the cycle after a pop, so capture is driven by the inflight flag.
  rd_skid_buf #(
    .WIDTH(ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight_q),
    .wr_data (skid_wr_data),
    .rd_valid(out_valid),
    .rd_ready(out_ready),
    .rd_data (skid_rd_data),
    .count   (skid_cnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; RUN leaves on the final pop so no extra idle cycle is spent.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = (burst_len != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (rd_en && ((issued_q + LENWIDTH'(1)) == len_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer_c && ((accepted_q + LENWIDTH'(1)) == len_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst length capture, pop/accept counters and the read-latency flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (start_ok_c) begin
        len_q      <= burst_len;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (rd_en)  issued_q   <= issued_q + LENWIDTH'(1);
        if (xfer_c) accepted_q <= accepted_q + LENWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO and stream model checked every cycle,
// plus literal expectations for the basic burst, zero length, reset and parity cases.
module tb_fifo_burst_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          f_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          rd_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
`ifdef FIFO_RD_PARITY_EN
  logic          out_par;
`endif

  fifo_burst_reader #(.DATAWIDTH(DW), .LENWIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .burst_len(burst_len),
    .f_empty  (f_empty),
    .fifo_data(fifo_data),
    .rd_en    (rd_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
`ifdef FIFO_RD_PARITY_EN
    ,
    .out_par  (out_par)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];   // words still inside the FIFO
  logic [DW-1:0] exp_q[$];    // words popped but not yet accepted downstream
  logic [DW-1:0] got_q[$];    // words actually accepted downstream
  bit            got_par[$];

  // Burst model in terms of words popped / captured / accepted.
  bit m_busy, m_done, m_prev_rd;
  int m_len, m_pops, m_acc, m_cap;

  bit            s_rd, s_valid, s_done, s_busy;
  logic [DW-1:0] s_data;
  int            n_xfer = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    f_empty = 1'b0;
  endtask

  task automatic model_clear();
    m_busy = 0; m_done = 0; m_prev_rd = 0;
    m_len = 0; m_pops = 0; m_acc = 0; m_cap = 0;
    exp_q.delete();
  endtask

  // One clock: compare at negedge against the model, then advance the FIFO after posedge.
  task automatic tick();
    bit e_valid, e_xfer, e_rd;
    @(negedge clk);
    s_rd = rd_en; s_valid = out_valid; s_done = done; s_busy = busy; s_data = out_data;
    e_valid = (m_cap > m_acc);
    e_xfer  = e_valid && out_ready;
    e_rd    = m_busy && !m_done && (m_pops < m_len) && !f_empty
              && ((m_pops - m_acc - int'(e_xfer)) < 2);
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("rd_en", int'(rd_en), int'(e_rd));
    check("out_valid", int'(out_valid), int'(e_valid));
    if (e_valid && exp_q.size() > 0) begin
      check("out_data", int'(out_data), int'(exp_q[0]));
`ifdef FIFO_RD_PARITY_EN
      check("out_par", int'(out_par), int'(^exp_q[0]));
`endif
    end
    check("occupancy_le_2", int'((m_pops - m_acc) <= 2), 1);
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
`ifdef FIFO_RD_PARITY_EN
      got_par.push_back(out_par);
`else
      got_par.push_back(^out_data);
`endif
      n_xfer++;
    end
    // advance model
    m_cap = m_cap + int'(m_prev_rd);
    m_prev_rd = rd_en;
    if (rd_en) m_pops++;
    if (e_xfer) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_acc++;
    end
    if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_len = int'(burst_len);
        m_pops = 0; m_acc = 0; m_cap = 0;
        if (burst_len == '0) m_done = 1;
      end
    end else if (e_xfer && m_acc == m_len) begin
      m_done = 1;
    end
    @(posedge clk);
    #1;
    if (s_rd && fifo_q.size() > 0) begin
      fifo_data = fifo_q.pop_front();
      exp_q.push_back(fifo_data);
    end
    f_empty = (fifo_q.size() == 0);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (s_done) seen = 1;
    end
    check("burst_completes", int'(seen), 1);
    tick();
  endtask

  logic [8:0]    lit_rd    = 9'b000011110;
  logic [8:0]    lit_valid = 9'b001111000;
  logic [8:0]    lit_done  = 9'b010000000;
  logic [8:0]    lit_busy  = 9'b011111110;
  logic [DW-1:0] lit_data [9] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00};
  int            x0;
  bit            seen;

  initial begin
    model_clear();
    #2;
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst of 4 at full rate
    for (int i = 1; i <= 4; i++) push(DW'(8'h10 + i));
    out_ready = 1'b1;
    start = 1'b1; burst_len = 8'd4;
    for (int c = 0; c < 9; c++) begin
      tick();
      check("basic_rd_en", int'(s_rd), int'(lit_rd[c]));
      check("basic_out_valid", int'(s_valid), int'(lit_valid[c]));
      check("basic_done", int'(s_done), int'(lit_done[c]));
      check("basic_busy", int'(s_busy), int'(lit_busy[c]));
      if (lit_valid[c]) check("basic_out_data", int'(s_data), int'(lit_data[c]));
    end

    // Backpressure: out_ready low for cycles 3..7 of a 6-word burst
    x0 = n_xfer;
    for (int i = 1; i <= 6; i++) push(DW'(8'h20 + i));
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (c == 0) begin start = 1'b1; burst_len = 8'd6; end
      tick();
      if (s_done) seen = 1;
    end
    check("bp_completes", int'(seen), 1);
    check("bp_words", n_xfer - x0, 6);
    out_ready = 1'b1;
    tick();

    // Starved FIFO: one word now, two more after 10 cycles
    x0 = n_xfer;
    push(8'h31);
    start = 1'b1; burst_len = 8'd3;
    for (int c = 0; c < 10; c++) tick();
    check("starved_partial", n_xfer - x0, 1);
    push(8'h32); push(8'h33);
    run_until_done(20);
    check("starved_words", n_xfer - x0, 3);
    check("starved_last", int'(got_q[got_q.size()-1]), 8'h33);

    // Zero length: no pop even with data present, done the cycle after start
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    start = 1'b1; burst_len = 8'd0;
    tick();
    check("zero_c0_done", int'(s_done), 0);
    check("zero_c0_rd", int'(s_rd), 0);
    tick();
    check("zero_c1_done", int'(s_done), 1);
    check("zero_c1_rd", int'(s_rd), 0);
    tick();
    check("zero_c2_busy", int'(s_busy), 0);
    check("zero_fifo_untouched", fifo_q.size(), 4);

    // Start during RUN is ignored
    x0 = n_xfer;
    start = 1'b1; burst_len = 8'd2;
    tick(); tick();
    start = 1'b1; burst_len = 8'd5;
    tick();
    burst_len = 8'd2;
    run_until_done(20);
    check("ignored_start_words", n_xfer - x0, 2);
    check("ignored_start_fifo_left", fifo_q.size(), 2);

    // Reset mid-burst with two words held in the skid buffer
    for (int i = 5; i <= 8; i++) push(DW'(8'h40 + i));
    out_ready = 1'b0;
    start = 1'b1; burst_len = 8'd5;
    for (int c = 0; c < 5; c++) tick();
    check("pre_reset_valid", int'(s_valid), 1);
    check("pre_reset_rd", int'(s_rd), 0);
    #1 rst = 1'b0;
    #1;
    check("mid_reset_valid", int'(out_valid), 0);
    check("mid_reset_rd", int'(rd_en), 0);
    check("mid_reset_busy", int'(busy), 0);
    model_clear();
    #1 rst = 1'b1;
    got_q.delete(); got_par.delete();
    out_ready = 1'b1;
    start = 1'b1; burst_len = 8'd2;
    run_until_done(20);
    check("post_reset_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("post_reset_w0", int'(got_q[0]), 8'h45);
      check("post_reset_w1", int'(got_q[1]), 8'h46);
    end

    // Parity words (drain the two leftovers first)
    start = 1'b1; burst_len = 8'd2;
    run_until_done(20);
    got_q.delete(); got_par.delete();
    push(8'h03); push(8'h07);
    start = 1'b1; burst_len = 8'd2;
    run_until_done(20);
    check("par_count", got_q.size(), 2);
`ifdef FIFO_RD_PARITY_EN
    if (got_par.size() == 2) begin
      check("par_w0", int'(got_par[0]), 0);
      check("par_w1", int'(got_par[1]), 1);
    end
`endif
    check("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
